// File: rtl/regbank_per.sv
// regbank_per: WIDTH x DEPTH register bank with one write port, two
// registered read ports (write-first bypass) and a sequential clear engine
// that zeroes one entry per clock while reporting busy / clr_done.
module regbank_per #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             clr_start,
  output logic             busy,
  output logic             clr_done,
  output logic             wr_err
);

  localparam int              IW       = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH-1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // True when an address selects a physically present entry.
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  state_t           state_r, state_s;
  logic [AW-1:0]    clr_idx_r, clr_idx_s;
  logic             clr_act_s;
  logic [IW-1:0]    clr_tgt_s;
  logic             wr_ok_s;
  logic [IW-1:0]    wr_idx_s;
  logic             done_s;
  logic             err_s;
  logic [WIDTH-1:0] rd_next_a_s;
  logic [WIDTH-1:0] rd_next_b_s;

  // Next-state logic: clear sequencing, write acceptance and status flags.
  always_comb begin
    state_s   = state_r;
    clr_idx_s = clr_idx_r;
    clr_act_s = 1'b0;
    clr_tgt_s = {IW{1'b0}};
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_start) begin
          clr_act_s = 1'b1;
          clr_tgt_s = {IW{1'b0}};
          clr_idx_s = AW'(1);
          state_s   = ST_CLEAR;
        end else begin
          clr_idx_s = clr_idx_r;
        end
      end
      ST_CLEAR: begin
        clr_act_s = 1'b1;
        clr_tgt_s = clr_idx_r[IW-1:0];
        if (clr_idx_r == LAST_IDX) begin
          clr_idx_s = {AW{1'b0}};
          state_s   = ST_IDLE;
          done_s    = 1'b1;
        end else begin
          clr_idx_s = clr_idx_r + AW'(1);
        end
      end
      default: begin
        state_s   = ST_IDLE;
        clr_idx_s = {AW{1'b0}};
      end
    endcase
    // Writes only land in IDLE, without a competing clear request, in range.
    wr_ok_s  = wr_en && (state_r == ST_IDLE) && !clr_start && addr_in_range(wr_addr);
    wr_idx_s = wr_addr[IW-1:0];
    err_s    = wr_en && !wr_ok_s;
  end

  // Post-edge value seen by read port A (clear/write bypass, zero when out of range).
  always_comb begin
    rd_next_a_s = {WIDTH{1'b0}};
    if (!addr_in_range(rd_addr_a)) begin
      rd_next_a_s = {WIDTH{1'b0}};
    end else if (clr_act_s && (clr_tgt_s == rd_addr_a[IW-1:0])) begin
      rd_next_a_s = {WIDTH{1'b0}};
    end else if (wr_ok_s && (wr_idx_s == rd_addr_a[IW-1:0])) begin
      rd_next_a_s = wr_data;
    end else begin
      rd_next_a_s = mem_r[rd_addr_a[IW-1:0]];
    end
  end

  // Post-edge value seen by read port B (clear/write bypass, zero when out of range).
  always_comb begin
    rd_next_b_s = {WIDTH{1'b0}};
    if (!addr_in_range(rd_addr_b)) begin
      rd_next_b_s = {WIDTH{1'b0}};
    end else if (clr_act_s && (clr_tgt_s == rd_addr_b[IW-1:0])) begin
      rd_next_b_s = {WIDTH{1'b0}};
    end else if (wr_ok_s && (wr_idx_s == rd_addr_b[IW-1:0])) begin
      rd_next_b_s = wr_data;
    end else begin
      rd_next_b_s = mem_r[rd_addr_b[IW-1:0]];
    end
  end

  // FSM state, clear index and registered status outputs.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_r   <= ST_IDLE;
      clr_idx_r <= {AW{1'b0}};
      busy      <= 1'b0;
      clr_done  <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state_r   <= state_s;
      clr_idx_r <= clr_idx_s;
      busy      <= (state_s == ST_CLEAR);
      clr_done  <= done_s;
      wr_err    <= err_s;
    end
  end

  // Storage array: a clear slot takes priority (writes are never accepted alongside it).
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (clr_act_s) begin
      mem_r[clr_tgt_s] <= {WIDTH{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[wr_idx_s] <= wr_data;
    end
  end

  // Registered read ports, one cycle latency.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      rd_data_a <= {WIDTH{1'b0}};
      rd_data_b <= {WIDTH{1'b0}};
    end else begin
      rd_data_a <= rd_next_a_s;
      rd_data_b <= rd_next_b_s;
    end
  end

endmodule
